// File: rtl/rv32i_types.sv
// Shared types for the RV32 back end: physical register and ROB widths, M-extension
// multiply encodings, and the multiply functional-unit sequencer state.
package rv32i_types;

    localparam int PREG_W_DEF = 6;
    localparam int ROB_W_DEF  = 5;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;

    typedef enum logic [2:0] {
        MFU_IDLE  = 3'd0,
        MFU_START = 3'd1,
        MFU_BUSY  = 3'd2,
        MFU_WB    = 3'd3,
        MFU_DRAIN = 3'd4
    } mul_fu_state_t;

endpackage

// File: rtl/mul_operand_fmt.sv
// Operand extension for the 33x33 signed core and selection of the 32-bit result word.
module mul_operand_fmt
    import rv32i_types::*;
(
    input  logic [2:0]  issue_funct3,
    input  logic [31:0] rs1_v,
    input  logic [31:0] rs2_v,
    output logic [32:0] a_ext,
    output logic [32:0] b_ext,
    input  logic [2:0]  op_funct3,
    input  logic [63:0] product,
    output logic [31:0] result
);

    always_comb begin
        a_ext = {rs1_v[31], rs1_v};
        b_ext = {rs2_v[31], rs2_v};
        case (issue_funct3)
            F3_MULHSU: b_ext = {1'b0, rs2_v};
            F3_MULHU: begin
                a_ext = {1'b0, rs1_v};
                b_ext = {1'b0, rs2_v};
            end
            default: ;
        endcase
    end

    // Unlisted encodings behave as MUL and therefore return the low word.
    always_comb begin
        result = product[31:0];
        case (op_funct3)
            F3_MULH, F3_MULHSU, F3_MULHU: result = product[63:32];
            default: ;
        endcase
    end

endmodule

// File: rtl/mul_fu_sequencer.sv
// Sequencer wrapping an external multiplier core: issue capture, start pulse,
// result capture, CDB handshake and flush draining.
//
//  state | meaning
//  IDLE  | ready for an issue
//  START | one-cycle start pulse to the core
//  BUSY  | waiting for core completion
//  WB    | requesting the CDB, result held stable
//  DRAIN | op squashed, waiting for the core to finish
module mul_fu_sequencer
    import rv32i_types::*;
#(
    parameter int PREG_W = PREG_W_DEF,
    parameter int ROB_W  = ROB_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              branch_flush,
    input  logic              issue_valid,
    input  logic [2:0]        issue_funct3,
    input  logic [PREG_W-1:0] issue_pd,
    input  logic [ROB_W-1:0]  issue_rob_idx,
    input  logic [31:0]       rs1_v,
    input  logic [31:0]       rs2_v,
    output logic              fu_ready,
    output logic              mul_start,
    output logic [32:0]       mul_a,
    output logic [32:0]       mul_b,
    input  logic              mul_done,
    input  logic [63:0]       mul_product,
    output logic              cdb_req,
    input  logic              cdb_grant,
    output logic [PREG_W-1:0] cdb_pd,
    output logic [ROB_W-1:0]  cdb_rob_idx,
    output logic [31:0]       cdb_value
);

    mul_fu_state_t     state, state_next;
    logic              load_issue, load_result;
    logic [2:0]        funct3_q;
    logic [PREG_W-1:0] pd_q;
    logic [ROB_W-1:0]  rob_q;
    logic [32:0]       a_q, b_q;
    logic [31:0]       result_q;
    logic [32:0]       a_fmt, b_fmt;
    logic [31:0]       result_fmt;

    mul_operand_fmt u_fmt (
        .issue_funct3 (issue_funct3),
        .rs1_v        (rs1_v),
        .rs2_v        (rs2_v),
        .a_ext        (a_fmt),
        .b_ext        (b_fmt),
        .op_funct3    (funct3_q),
        .product      (mul_product),
        .result       (result_fmt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= MFU_IDLE;
            funct3_q <= '0;
            pd_q     <= '0;
            rob_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            state <= state_next;
            if (load_issue) begin
                funct3_q <= issue_funct3;
                pd_q     <= issue_pd;
                rob_q    <= issue_rob_idx;
                a_q      <= a_fmt;
                b_q      <= b_fmt;
            end
            if (load_result) begin
                result_q <= result_fmt;
            end
        end
    end

    always_comb begin
        state_next  = state;
        load_issue  = 1'b0;
        load_result = 1'b0;
        case (state)
            MFU_IDLE: begin
                if (issue_valid && !branch_flush) begin
                    state_next = MFU_START;
                    load_issue = 1'b1;
                end
            end
            MFU_START: state_next = branch_flush ? MFU_DRAIN : MFU_BUSY;
            MFU_BUSY: begin
                // A completion that coincides with the flush leaves nothing to drain.
                if (branch_flush) begin
                    state_next = mul_done ? MFU_IDLE : MFU_DRAIN;
                end else if (mul_done) begin
                    state_next  = MFU_WB;
                    load_result = 1'b1;
                end
            end
            MFU_WB: begin
                if (branch_flush || cdb_grant) begin
                    state_next = MFU_IDLE;
                end
            end
            MFU_DRAIN: begin
                if (mul_done) begin
                    state_next = MFU_IDLE;
                end
            end
            default: state_next = MFU_IDLE;
        endcase
    end

    always_comb begin
        fu_ready    = (state == MFU_IDLE);
        mul_start   = (state == MFU_START);
        mul_a       = a_q;
        mul_b       = b_q;
        cdb_req     = (state == MFU_WB);
        cdb_pd      = cdb_req ? pd_q     : '0;
        cdb_rob_idx = cdb_req ? rob_q    : '0;
        cdb_value   = cdb_req ? result_q : '0;
    end

endmodule

// File: tb/tb_mul_fu_sequencer.sv
// Directed bench for mul_fu_sequencer with a behavioural multiplier core and a result scoreboard.
module tb_mul_fu_sequencer;
    import rv32i_types::*;

    logic        clk = 1'b0;
    logic        rst, branch_flush, issue_valid, mul_done, cdb_grant;
    logic [2:0]  issue_funct3;
    logic [5:0]  issue_pd;
    logic [4:0]  issue_rob_idx;
    logic [31:0] rs1_v, rs2_v;
    logic        fu_ready, mul_start, cdb_req;
    logic [32:0] mul_a, mul_b;
    logic [63:0] mul_product;
    logic [5:0]  cdb_pd;
    logic [4:0]  cdb_rob_idx;
    logic [31:0] cdb_value;

    typedef struct packed {
        logic [5:0]  pd;
        logic [4:0]  rob;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    mul_fu_sequencer #(.PREG_W(6), .ROB_W(5)) dut (
        .clk           (clk),
        .rst           (rst),
        .branch_flush  (branch_flush),
        .issue_valid   (issue_valid),
        .issue_funct3  (issue_funct3),
        .issue_pd      (issue_pd),
        .issue_rob_idx (issue_rob_idx),
        .rs1_v         (rs1_v),
        .rs2_v         (rs2_v),
        .fu_ready      (fu_ready),
        .mul_start     (mul_start),
        .mul_a         (mul_a),
        .mul_b         (mul_b),
        .mul_done      (mul_done),
        .mul_product   (mul_product),
        .cdb_req       (cdb_req),
        .cdb_grant     (cdb_grant),
        .cdb_pd        (cdb_pd),
        .cdb_rob_idx   (cdb_rob_idx),
        .cdb_value     (cdb_value)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_fu_ready"}, fu_ready, 1);
        check({tag, "_mul_start"}, mul_start, 0);
        check({tag, "_cdb_req"}, cdb_req, 0);
        check({tag, "_cdb_pd"}, cdb_pd, 0);
        check({tag, "_cdb_rob"}, cdb_rob_idx, 0);
        check({tag, "_cdb_value"}, cdb_value, 0);
        check({tag, "_mul_a"}, mul_a, 0);
        check({tag, "_mul_b"}, mul_b, 0);
    endtask

    task automatic core_product();
        logic signed [32:0] sa, sb_op;
        logic signed [65:0] p;
        sa = mul_a;
        sb_op = mul_b;
        p = sa * sb_op;
        mul_product = p[63:0];
    endtask

    // Drives one issue; leaves the sequencer in START (cycle issue+1).
    task automatic do_issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input logic [5:0] pd, input logic [4:0] rob);
        issue_valid = 1'b1;
        issue_funct3 = f3;
        rs1_v = a;
        rs2_v = b;
        issue_pd = pd;
        issue_rob_idx = rob;
        step();
        issue_valid = 1'b0;
    endtask

    // Core latency 4: done pulse in cycle issue+6, request visible in cycle issue+7.
    task automatic go_to_wb(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input logic [5:0] pd, input logic [4:0] rob,
                            input logic [32:0] exp_a, input logic [32:0] exp_b);
        do_issue(f3, a, b, pd, rob);
        check("start_pulse", mul_start, 1);
        check("busy_not_ready", fu_ready, 0);
        check("mul_a_ext", mul_a, exp_a);
        check("mul_b_ext", mul_b, exp_b);
        step();
        check("start_one_cycle", mul_start, 0);
        repeat (4) step();
        check("no_req_before_done", cdb_req, 0);
        core_product();
        mul_done = 1'b1;
        step();
        mul_done = 1'b0;
        check("req_at_issue_plus_7", cdb_req, 1);
    endtask

    task automatic broadcast(input int wait_cycles);
        exp_t e;
        int n = 0;
        while (!cdb_req && n < 20) begin
            step();
            n++;
        end
        check("req_wait_bound", cdb_req, 1);
        checks++;
        assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL sb_underflow observed=%0d expected=>0", sb.size());
        end
        if (sb.size() == 0) return;
        e = sb.pop_front();
        for (int i = 0; i < wait_cycles; i++) begin
            check("hold_req", cdb_req, 1);
            check("hold_pd", cdb_pd, e.pd);
            check("hold_rob", cdb_rob_idx, e.rob);
            check("hold_value", cdb_value, e.val);
            if (i > 0) begin
                issue_valid = 1'b1;
                issue_funct3 = F3_MUL;
                rs1_v = 32'd9;
                rs2_v = 32'd9;
                issue_pd = 6'h3f;
                issue_rob_idx = 5'h1f;
            end
            step();
            check("ignored_issue_in_wb", mul_start, 0);
        end
        issue_valid = 1'b0;
        check("cdb_pd", cdb_pd, e.pd);
        check("cdb_rob", cdb_rob_idx, e.rob);
        check("cdb_value", cdb_value, e.val);
        cdb_grant = 1'b1;
        step();
        cdb_grant = 1'b0;
        check("ready_after_grant", fu_ready, 1);
        check("req_drop_after_grant", cdb_req, 0);
        check("value_zero_after_grant", cdb_value, 0);
        check("no_start_after_grant", mul_start, 0);
    endtask

    initial begin
        rst = 1'b1;
        branch_flush = 1'b0;
        issue_valid = 1'b0;
        issue_funct3 = '0;
        issue_pd = '0;
        issue_rob_idx = '0;
        rs1_v = '0;
        rs2_v = '0;
        mul_done = 1'b0;
        mul_product = '0;
        cdb_grant = 1'b0;
        step();
        step();
        rst = 1'b0;
        check_reset_outputs("reset");

        // stray completion and grant in IDLE do nothing
        mul_done = 1'b1;
        cdb_grant = 1'b1;
        step();
        mul_done = 1'b0;
        cdb_grant = 1'b0;
        check("idle_done_ignored", cdb_req, 0);
        check("idle_still_ready", fu_ready, 1);

        sb.push_back('{pd: 6'd5, rob: 5'd3, val: 32'h0000002A});
        go_to_wb(F3_MUL, 32'd7, 32'd6, 6'd5, 5'd3, 33'h0_00000007, 33'h0_00000006);
        broadcast(0);

        sb.push_back('{pd: 6'd12, rob: 5'd7, val: 32'hFFFFFFFF});
        go_to_wb(F3_MULH, 32'hFFFFFFFE, 32'd3, 6'd12, 5'd7, 33'h1_FFFFFFFE, 33'h0_00000003);
        broadcast(0);

        sb.push_back('{pd: 6'd33, rob: 5'd17, val: 32'hFFFFFFFE});
        go_to_wb(F3_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd33, 5'd17, 33'h0_FFFFFFFF, 33'h0_FFFFFFFF);
        broadcast(0);

        sb.push_back('{pd: 6'd63, rob: 5'd31, val: 32'hFFFFFFFF});
        go_to_wb(F3_MULHSU, 32'hFFFFFFFF, 32'd2, 6'd63, 5'd31, 33'h1_FFFFFFFF, 33'h0_00000002);
        broadcast(5);

        // flush in BUSY, completion two cycles later, extra flush while draining
        do_issue(F3_MUL, 32'd3, 32'd4, 6'd1, 5'd1);
        step();
        branch_flush = 1'b1;
        step();
        check("drain_not_ready", fu_ready, 0);
        check("drain_no_req", cdb_req, 0);
        step();
        branch_flush = 1'b0;
        check("drain_hold_on_flush", fu_ready, 0);
        check("drain_no_start", mul_start, 0);
        core_product();
        mul_done = 1'b1;
        step();
        mul_done = 1'b0;
        check("drain_to_idle", fu_ready, 1);
        check("drain_no_broadcast", cdb_req, 0);
        step();
        check("drain_still_no_req", cdb_req, 0);

        // flush coincident with completion
        do_issue(F3_MULH, 32'd100, 32'd200, 6'd2, 5'd2);
        step();
        branch_flush = 1'b1;
        core_product();
        mul_done = 1'b1;
        step();
        branch_flush = 1'b0;
        mul_done = 1'b0;
        check("flush_done_idle", fu_ready, 1);
        check("flush_done_no_req", cdb_req, 0);
        step();
        check("flush_done_no_req_later", cdb_req, 0);

        // flush in WB
        go_to_wb(F3_MUL, 32'd11, 32'd13, 6'd4, 5'd4, 33'h0_0000000B, 33'h0_0000000D);
        branch_flush = 1'b1;
        step();
        branch_flush = 1'b0;
        check("wb_flush_req_low", cdb_req, 0);
        check("wb_flush_value_zero", cdb_value, 0);
        check("wb_flush_ready", fu_ready, 1);

        // flush coincident with IDLE issue
        issue_valid = 1'b1;
        branch_flush = 1'b1;
        issue_funct3 = F3_MUL;
        rs1_v = 32'd2;
        rs2_v = 32'd2;
        step();
        issue_valid = 1'b0;
        branch_flush = 1'b0;
        check("idle_flush_no_start", mul_start, 0);
        check("idle_flush_ready", fu_ready, 1);
        step();
        check("idle_flush_no_start_later", mul_start, 0);

        // reset in BUSY
        do_issue(F3_MULHU, 32'hDEADBEEF, 32'h12345678, 6'd9, 5'd9);
        step();
        check("busy_before_reset", fu_ready, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_outputs("busy_reset");

        // undefined funct3 behaves as MUL: 5 * -3 low word
        sb.push_back('{pd: 6'd21, rob: 5'd10, val: 32'hFFFFFFF1});
        go_to_wb(3'b101, 32'd5, 32'hFFFFFFFD, 6'd21, 5'd10, 33'h0_00000005, 33'h1_FFFFFFFD);
        broadcast(1);

        check("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
